// File: rtl/riscv_v_logic_alu_seq_pkg.sv
// Shared types for the vector logical-op sequencer: op encoding, FSM states,
// element-size vector and the ALU source/result containers.
package riscv_v_logic_alu_seq_pkg;

    localparam int MAX_LMUL   = 8;
    localparam int ALU_DATA_W = 64;

    typedef enum logic [1:0] {
        LOGIC_AND    = 2'd0,
        LOGIC_OR     = 2'd1,
        LOGIC_REDAND = 2'd2,
        LOGIC_REDOR  = 2'd3
    } riscv_v_logic_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // One-hot element size: bit0 e8, bit1 e16, bit2 e32, bit3 e64
    typedef logic [3:0] osize_vector_t;

    typedef struct packed {
        logic                  valid;
        logic [ALU_DATA_W-1:0] data;
    } riscv_v_alu_data_t;

    typedef struct packed {
        logic                  valid;
        logic [ALU_DATA_W-1:0] data;
    } riscv_v_wb_data_t;

    function automatic logic op_is_reduct(input riscv_v_logic_op_t op);
        return (op == LOGIC_REDAND) || (op == LOGIC_REDOR);
    endfunction

    function automatic logic op_is_and(input riscv_v_logic_op_t op);
        return (op == LOGIC_AND) || (op == LOGIC_REDAND);
    endfunction

endpackage

// File: rtl/riscv_v_logic_alu_seq_stage.sv
// Read-return tracking (p0) and the S1 register that feeds the ALU, plus the
// reduction accumulator. All ALU-facing outputs come straight from registers,
// except srcb, which selects the accumulator for reduction chunks after the first.
module riscv_v_logic_alu_seq_stage
    import riscv_v_logic_alu_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_fire,
    input  logic [CNT_W-1:0]      i_rd_k,
    input  logic                  i_rd_last,
    input  logic                  i_is_and,
    input  logic                  i_is_or,
    input  logic                  i_is_reduct,
    input  osize_vector_t         i_osize,
    input  riscv_v_alu_data_t     i_rdata_a,
    input  riscv_v_alu_data_t     i_rdata_b,
    input  logic [ALU_DATA_W-1:0] i_acc_din,
    output logic                  o_vld_p0,
    output logic                  o_vld_p1,
    output logic [CNT_W-1:0]      o_k_p1,
    output logic                  o_last_p1,
    output logic                  o_is_and,
    output logic                  o_is_or,
    output logic                  o_is_reduct,
    output osize_vector_t         o_osize,
    output riscv_v_alu_data_t     o_srca,
    output riscv_v_alu_data_t     o_srcb
);

    logic                  r_vld_p0;
    logic [CNT_W-1:0]      r_k_p0;
    logic                  r_last_p0;
    logic                  r_vld_p1;
    logic [CNT_W-1:0]      r_k_p1;
    logic                  r_last_p1;
    logic                  r_is_and_p1;
    logic                  r_is_or_p1;
    logic                  r_is_reduct_p1;
    osize_vector_t         r_osize_p1;
    logic                  r_srca_vld_p1;
    logic                  r_srcb_vld_p1;
    logic [ALU_DATA_W-1:0] r_srca_data_p1;
    logic [ALU_DATA_W-1:0] r_srcb_data_p1;
    logic                  r_use_acc_p1;
    logic [ALU_DATA_W-1:0] r_acc;

    // Control: valid pipeline, registered ALU controls, accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p0       <= 1'b0;
            r_vld_p1       <= 1'b0;
            r_is_and_p1    <= 1'b0;
            r_is_or_p1     <= 1'b0;
            r_is_reduct_p1 <= 1'b0;
            r_osize_p1     <= '0;
            r_srca_vld_p1  <= 1'b0;
            r_srcb_vld_p1  <= 1'b0;
            r_use_acc_p1   <= 1'b0;
            r_acc          <= '0;
        end else begin
            // p0 -> S1: read data arrives this cycle, capture it with its chunk
            r_vld_p0       <= i_rd_fire;
            r_vld_p1       <= r_vld_p0;
            r_is_and_p1    <= r_vld_p0 & i_is_and;
            r_is_or_p1     <= r_vld_p0 & ~i_is_and & i_is_or;
            r_is_reduct_p1 <= r_vld_p0 & i_is_reduct;
            r_osize_p1     <= r_vld_p0 ? i_osize : '0;
            r_srca_vld_p1  <= r_vld_p0 & (i_is_reduct ? i_rdata_b.valid : i_rdata_a.valid);
            r_srcb_vld_p1  <= r_vld_p0 & (i_is_reduct ? i_rdata_a.valid : i_rdata_b.valid);
            r_use_acc_p1   <= r_vld_p0 & i_is_reduct & (r_k_p0 != '0);
            if (r_vld_p1) begin
                r_acc <= i_acc_din;
            end
        end
    end

    // Data: chunk index and operand capture, no reset needed
    always_ff @(posedge clk) begin
        if (i_rd_fire) begin
            r_k_p0    <= i_rd_k;
            r_last_p0 <= i_rd_last;
        end
        if (r_vld_p0) begin
            r_k_p1         <= r_k_p0;
            r_last_p1      <= r_last_p0;
            // Reductions chain vs2 chunks through srca; vs1 chunk 0 seeds srcb
            r_srca_data_p1 <= i_is_reduct ? i_rdata_b.data : i_rdata_a.data;
            r_srcb_data_p1 <= i_is_reduct ? i_rdata_a.data : i_rdata_b.data;
        end
    end

    assign o_vld_p0    = r_vld_p0;
    assign o_vld_p1    = r_vld_p1;
    assign o_k_p1      = r_k_p1;
    assign o_last_p1   = r_last_p1;
    assign o_is_and    = r_is_and_p1;
    assign o_is_or     = r_is_or_p1;
    assign o_is_reduct = r_is_reduct_p1;
    assign o_osize     = r_osize_p1;
    assign o_srca      = {r_srca_vld_p1, r_srca_data_p1};
    assign o_srcb      = r_use_acc_p1 ? {1'b1, r_acc} : {r_srcb_vld_p1, r_srcb_data_p1};

endmodule

// File: rtl/riscv_v_logic_alu_seq.sv
// Sequencer for vector logical ops over a register group: accepts one
// instruction, reads one chunk per cycle from the VRF, drives the ALU from the
// S1 stage and writes results back (one scalar write for reductions).
module riscv_v_logic_alu_seq
    import riscv_v_logic_alu_seq_pkg::*;
#(
    parameter int MAX_CHUNKS = 8,
    parameter int REG_ADDR_W = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  riscv_v_logic_op_t             req_op,
    input  osize_vector_t                 req_osize_vector,
    input  logic [REG_ADDR_W-1:0]         req_vs1,
    input  logic [REG_ADDR_W-1:0]         req_vs2,
    input  logic [REG_ADDR_W-1:0]         req_vd,
    input  logic [$clog2(MAX_CHUNKS):0]   req_nchunks,
    output logic                          rf_rd_en,
    output logic [REG_ADDR_W-1:0]         rf_rd_addr_a,
    output logic [REG_ADDR_W-1:0]         rf_rd_addr_b,
    input  riscv_v_alu_data_t             rf_rdata_a,
    input  riscv_v_alu_data_t             rf_rdata_b,
    output logic                          alu_is_and,
    output logic                          alu_is_or,
    output logic                          alu_is_reduct,
    output osize_vector_t                 alu_osize_vector,
    output riscv_v_alu_data_t             alu_srca,
    output riscv_v_alu_data_t             alu_srcb,
    input  riscv_v_wb_data_t              alu_result,
    output logic                          wb_valid,
    output logic [REG_ADDR_W-1:0]         wb_addr,
    output riscv_v_wb_data_t              wb_data,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_CHUNKS) + 1;

    seq_state_t            r_state;
    logic [CNT_W-1:0]      r_k;
    logic [CNT_W-1:0]      r_n;
    riscv_v_logic_op_t     r_op;
    osize_vector_t         r_osize;
    logic [REG_ADDR_W-1:0] r_vs1;
    logic [REG_ADDR_W-1:0] r_vs2;
    logic [REG_ADDR_W-1:0] r_vd;

    logic                  w_accept;
    logic                  w_last_rd;
    logic [CNT_W-1:0]      w_n_eff;
    logic                  w_vld_p0;
    logic                  w_vld_p1;
    logic [CNT_W-1:0]      w_k_p1;
    logic                  w_last_p1;

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_last_rd = (r_k == (r_n - CNT_W'(1)));

    // Chunk count normalisation: 0 runs as one chunk, oversize clamps to MAX_CHUNKS
    always_comb begin
        w_n_eff = req_nchunks;
        if (req_nchunks == '0) begin
            w_n_eff = CNT_W'(1);
        end else if (req_nchunks > CNT_W'(MAX_CHUNKS)) begin
            w_n_eff = CNT_W'(MAX_CHUNKS);
        end
    end

    // Sequencer FSM and chunk counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_k <= '0;
                    if (w_accept) begin
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (w_last_rd) begin
                        r_state <= DRAIN;
                    end else begin
                        r_k <= r_k + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (!w_vld_p0) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Instruction fields latched at accept; later request changes are ignored
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= req_op;
            r_osize <= req_osize_vector;
            r_vs1   <= req_vs1;
            r_vs2   <= req_vs2;
            r_vd    <= req_vd;
            r_n     <= w_n_eff;
        end
    end

    assign req_ready    = (r_state == IDLE);
    assign busy         = (r_state != IDLE);
    assign rf_rd_en     = (r_state == READ);
    assign rf_rd_addr_a = r_vs1 + REG_ADDR_W'(r_k);
    assign rf_rd_addr_b = r_vs2 + REG_ADDR_W'(r_k);

    riscv_v_logic_alu_seq_stage #(
        .CNT_W (CNT_W)
    ) u_stage (
        .clk         (clk),
        .rst         (rst),
        .i_rd_fire   (rf_rd_en),
        .i_rd_k      (r_k),
        .i_rd_last   (w_last_rd),
        .i_is_and    (op_is_and(r_op)),
        .i_is_or     (!op_is_and(r_op)),
        .i_is_reduct (op_is_reduct(r_op)),
        .i_osize     (r_osize),
        .i_rdata_a   (rf_rdata_a),
        .i_rdata_b   (rf_rdata_b),
        .i_acc_din   (alu_result.data),
        .o_vld_p0    (w_vld_p0),
        .o_vld_p1    (w_vld_p1),
        .o_k_p1      (w_k_p1),
        .o_last_p1   (w_last_p1),
        .o_is_and    (alu_is_and),
        .o_is_or     (alu_is_or),
        .o_is_reduct (alu_is_reduct),
        .o_osize     (alu_osize_vector),
        .o_srca      (alu_srca),
        .o_srcb      (alu_srcb)
    );

    assign wb_valid = w_vld_p1 && (!alu_is_reduct || w_last_p1);
    assign wb_addr  = alu_is_reduct ? r_vd : (r_vd + REG_ADDR_W'(w_k_p1));
    assign wb_data  = alu_result;

endmodule

// File: tb/tb_riscv_v_logic_alu_seq.sv
// Directed bench for the vector logical-op sequencer with a VRF and ALU model.
module tb_riscv_v_logic_alu_seq;
    import riscv_v_logic_alu_seq_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    riscv_v_logic_op_t req_op;
    osize_vector_t     req_osize_vector;
    logic [4:0]        req_vs1, req_vs2, req_vd;
    logic [3:0]        req_nchunks;
    logic              rf_rd_en;
    logic [4:0]        rf_rd_addr_a, rf_rd_addr_b;
    riscv_v_alu_data_t rf_rdata_a, rf_rdata_b;
    logic              alu_is_and, alu_is_or, alu_is_reduct;
    osize_vector_t     alu_osize_vector;
    riscv_v_alu_data_t alu_srca, alu_srcb;
    riscv_v_wb_data_t  alu_result;
    logic              wb_valid;
    logic [4:0]        wb_addr;
    riscv_v_wb_data_t  wb_data;
    logic              busy;

    riscv_v_logic_alu_seq #(.MAX_CHUNKS(8), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_osize_vector(req_osize_vector),
        .req_vs1(req_vs1), .req_vs2(req_vs2), .req_vd(req_vd), .req_nchunks(req_nchunks),
        .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .alu_is_and(alu_is_and), .alu_is_or(alu_is_or), .alu_is_reduct(alu_is_reduct),
        .alu_osize_vector(alu_osize_vector), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int c; int a; int b; } rd_ev_t;
    typedef struct { int c; int addr; logic [63:0] d; } wb_ev_t;

    logic [63:0]   vrf [32];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            red_cnt = 0;
    osize_vector_t last_osize = '0;
    rd_ev_t        rd_q[$];
    wb_ev_t        wb_q[$];
    int            acc_q[$];

    // VRF read port: one-cycle latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rf_rdata_a <= {rf_rd_en, vrf[rf_rd_addr_a]};
        rf_rdata_b <= {rf_rd_en, vrf[rf_rd_addr_b]};
        if (req_valid && req_ready && !rst) acc_q.push_back(cyc);
    end

    // Combinational logical ALU
    always_comb begin
        alu_result.valid = alu_srca.valid & alu_srcb.valid;
        alu_result.data  = '0;
        if (alu_is_and)     alu_result.data = alu_srca.data & alu_srcb.data;
        else if (alu_is_or) alu_result.data = alu_srca.data | alu_srcb.data;
    end

    // Event log sampled mid-cycle
    always @(negedge clk) begin
        if (rf_rd_en) rd_q.push_back('{cyc, int'(rf_rd_addr_a), int'(rf_rd_addr_b)});
        if (wb_valid) wb_q.push_back('{cyc, int'(wb_addr), wb_data.data});
        if (alu_is_reduct) red_cnt++;
        if (alu_is_and || alu_is_or) last_osize = alu_osize_vector;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(output int c);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        if (!req_ready) check_val("ready_timeout", {63'd0, req_ready}, 64'd1);
        c = cyc;
    endtask

    task automatic check_op(input int x0, input bit is_red, input bit is_or,
                            input int vs1, input int vs2, input int vd, input int n);
        rd_ev_t      r;
        wb_ev_t      w;
        logic [63:0] e;
        for (int k = 0; k < n; k++) begin
            if (rd_q.size() == 0) begin
                check_val("rd_missing", rd_q.size(), n - k);
            end else begin
                r = rd_q.pop_front();
                check_val("rd_cyc", r.c, x0 + k + 1);
                check_val("rd_addr_a", r.a, (vs1 + k) % 32);
                check_val("rd_addr_b", r.b, (vs2 + k) % 32);
            end
        end
        if (!is_red) begin
            for (int k = 0; k < n; k++) begin
                e = is_or ? (vrf[(vs1 + k) % 32] | vrf[(vs2 + k) % 32])
                          : (vrf[(vs1 + k) % 32] & vrf[(vs2 + k) % 32]);
                if (wb_q.size() == 0) begin
                    check_val("wb_missing", wb_q.size(), n - k);
                end else begin
                    w = wb_q.pop_front();
                    check_val("wb_cyc", w.c, x0 + k + 3);
                    check_val("wb_addr", w.addr, (vd + k) % 32);
                    check_val("wb_data", w.d, e);
                end
            end
        end else begin
            e = vrf[vs1];
            for (int k = 0; k < n; k++)
                e = is_or ? (e | vrf[(vs2 + k) % 32]) : (e & vrf[(vs2 + k) % 32]);
            if (wb_q.size() == 0) begin
                check_val("red_wb_missing", wb_q.size(), 1);
            end else begin
                w = wb_q.pop_front();
                check_val("red_wb_cyc", w.c, x0 + n + 2);
                check_val("red_wb_addr", w.addr, vd);
                check_val("red_wb_data", w.d, e);
            end
        end
    endtask

    task automatic run_op(input riscv_v_logic_op_t op, input osize_vector_t os,
                          input int vs1, input int vs2, input int vd, input int nch);
        int x0, c, neff;
        neff = (nch == 0) ? 1 : ((nch > 8) ? 8 : nch);
        check_val("ready_pre", {63'd0, req_ready}, 64'd1);
        x0 = cyc;
        req_op = op; req_osize_vector = os;
        req_vs1 = 5'(vs1); req_vs2 = 5'(vs2); req_vd = 5'(vd); req_nchunks = 4'(nch);
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        wait_ready(c);
        check_val("ready_cyc", c, x0 + neff + 3);
        check_op(x0, op_is_reduct(op), !op_is_and(op), vs1, vs2, vd, neff);
        check_val("rd_extra", rd_q.size(), 0);
        check_val("wb_extra", wb_q.size(), 0);
    endtask

    initial begin
        int x0, c;
        for (int i = 0; i < 32; i++)
            vrf[i] = {8'(i), 8'(i) ^ 8'hA5, 16'h0F0F << (i % 8), ~(32'h3 << i)};
        rst = 1'b1; req_valid = 1'b0; req_op = LOGIC_AND; req_osize_vector = '0;
        req_vs1 = '0; req_vs2 = '0; req_vd = '0; req_nchunks = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_val("rst_ready", {63'd0, req_ready}, 64'd1);
        check_val("rst_rd_en", {63'd0, rf_rd_en}, 64'd0);
        check_val("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_is_and", {63'd0, alu_is_and}, 64'd0);
        check_val("rst_is_or", {63'd0, alu_is_or}, 64'd0);
        check_val("rst_is_reduct", {63'd0, alu_is_reduct}, 64'd0);
        check_val("rst_osize", {60'd0, alu_osize_vector}, 64'd0);
        check_val("rst_srca_vld", {63'd0, alu_srca.valid}, 64'd0);
        check_val("rst_srcb_vld", {63'd0, alu_srcb.valid}, 64'd0);

        // AND e8, single chunk
        run_op(LOGIC_AND, 4'b0001, 2, 4, 6, 1);
        // OR e32, vs2 wraps past 31
        run_op(LOGIC_OR, 4'b0100, 10, 30, 16, 4);
        check_val("osize_e32", {60'd0, last_osize}, 64'h4);
        // REDAND e64 over a full group
        red_cnt = 0;
        run_op(LOGIC_REDAND, 4'b1000, 5, 8, 1, 8);
        check_val("red_cycles", red_cnt, 8);
        // REDOR with oversize count clamped to 8, vs2 wraps
        run_op(LOGIC_REDOR, 4'b0010, 0, 28, 31, 12);

        // Reset in cycle 2 of an N=4 op abandons it
        x0 = cyc;
        req_op = LOGIC_AND; req_osize_vector = 4'b0001;
        req_vs1 = 5'd1; req_vs2 = 5'd3; req_vd = 5'd7; req_nchunks = 4'd4;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_ready", {63'd0, req_ready}, 64'd1);
        check_val("abort_busy", {63'd0, busy}, 64'd0);
        check_val("abort_cyc", cyc, x0 + 3);
        repeat (6) @(negedge clk);
        check_val("abort_no_wb", wb_q.size(), 0);
        check_val("abort_rd_cnt", rd_q.size(), 2);
        rd_q.delete();
        run_op(LOGIC_OR, 4'b0001, 12, 14, 3, 2);

        // req_valid held while busy: second op only at cycle N+3; nchunks=0 runs once
        acc_q.delete();
        x0 = cyc;
        req_op = LOGIC_AND; req_osize_vector = 4'b0001;
        req_vs1 = 5'd3; req_vs2 = 5'd9; req_vd = 5'd12; req_nchunks = 4'd0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_op = LOGIC_OR; req_vs1 = 5'd10; req_vs2 = 5'd11; req_vd = 5'd20; req_nchunks = 4'd2;
        for (int i = 0; i < 20 && acc_q.size() < 2; i++) @(negedge clk);
        req_valid = 1'b0;
        check_val("hold_acc_cnt", acc_q.size(), 2);
        if (acc_q.size() >= 2) begin
            check_val("hold_acc0", acc_q[0], x0);
            check_val("hold_acc1", acc_q[1], x0 + 4);
        end
        wait_ready(c);
        check_val("hold_ready_cyc", c, x0 + 9);
        check_op(x0, 1'b0, 1'b0, 3, 9, 12, 1);
        check_op(x0 + 4, 1'b0, 1'b1, 10, 11, 20, 2);
        check_val("hold_wb_extra", wb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
